dht11_uart_reporter: RTL and testbench
======================================

// Module: dht11_uart_reporter
// PURPOSE
//  Consumes each completed DHT11 reading (humidity, temperature, checksum flag) and
//  streams it as a fixed 13-byte ASCII line to the UART transmitter, e.g. "H=045 T=023\r\n".
//  Sits between dht11_controller (producer) and the uart tx path (consumer).
//  Converts binary to 3 decimal digits internally, using double-dabble.
//  Paces bytes with the tx_busy/tx_done handshake.
// PARAMETERS
//  TAG_H    8'h48  first byte of the line ('H')
//  TAG_T    8'h54  seventh byte of the line ('T')
//  ERR_CHR  8'h2D  digit substitute when the checksum fails ('-')
// PORTS
//  clk          in   1  system clock, single domain
//  reset        in   1  synchronous, active-high reset
//  i_valid      in   1  one-cycle pulse: a new reading is on i_humidity/i_temperature/i_chk_ok
//  i_humidity   in   8  humidity, binary 0..255
//  i_temperature in  8  temperature, binary 0..255
//  i_chk_ok     in   1  1 = DHT11 checksum matched
//  tx_busy      in   1  uart tx is shifting a byte
//  tx_done      in   1  one-cycle pulse: uart tx finished the current byte
//  tx_start     out  1  one-cycle request to send tx_data
//  tx_data      out  8  byte to transmit
//  o_busy       out  1  a line is being converted or sent
//  o_drop       out  1  one-cycle pulse: i_valid arrived while o_busy=1 and was discarded
// BEHAVIOUR
//  Reset: tx_start=0, tx_data=8'h00, o_busy=0, o_drop=0, state=IDLE, byte index=0.
//   Reset has priority on every cycle, including mid-line; no further tx_start follows it.
//  All outputs are registered.
//  Line layout, indices 0..12:
//   TAG_H, '=', H2, H1, H0, ' ', TAG_T, '=', T2, T1, T0, 8'h0D, 8'h0A.
//   Hx/Tx = 8'h30 + BCD digit (hundreds, tens, units).
//   If i_chk_ok=0 at capture, all six digits are ERR_CHR.
//  FSM:
//   IDLE: on i_valid=1, latch all three inputs and go to CONV; o_busy=1 from the next cycle.
//   CONV: exactly 8 cycles of double-dabble on both values in parallel (add-3 then shift),
//    then go to SEND with index=0.
//   SEND: wait while tx_busy=1. When tx_busy=0, pulse tx_start for 1 cycle,
//    drive tx_data=line[index], and go to WAIT.
//   WAIT: hold tx_data stable until tx_done=1.
//    On tx_done: if index=12 go to IDLE and o_busy=0 next cycle; else index+1 and go to SEND.
//    tx_done outside WAIT is ignored.
//  Latency: first tx_start rises 9 clocks after the edge that samples i_valid=1,
//   provided tx_busy=0.
//  i_valid while o_busy=1: the reading is discarded, o_drop pulses 1 cycle,
//   and the line in progress is unaffected.
//  i_valid in the same cycle that WAIT returns to IDLE also counts as busy and is dropped.
//  Exactly 13 tx_start pulses per accepted reading; never two without an intervening tx_done.
//  Digit math: 255 -> "255", 0 -> "000". No leading-zero suppression and no sign.
// TESTING
//  1. H=45, T=23, chk_ok=1, tx_done 20 clk after each start
//     -> bytes 48 3D 30 34 35 20 54 3D 30 32 33 0D 0A, then o_busy=0.
//  2. H=255, T=0 -> digit bytes 32 35 35 and 30 30 30; first tx_start exactly 9 clk after i_valid.
//  3. chk_ok=0, H=99, T=99 -> bytes 2-4 and 8-10 all 2D; framing bytes unchanged.
//  4. Second i_valid during byte 5 -> o_drop=1 for one cycle; first line completes with original values.
//  5. tx_busy held high 50 clk on entering SEND -> tx_start stays 0 until tx_busy falls, then pulses once.
//  6. reset asserted after the 5th tx_done -> next cycle all outputs at reset values;
//     no more tx_start; a new i_valid is accepted normally.

Source files
------------

// File: rtl/dht11_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_uart_reporter
//  Description : Formats each DHT11 reading as the 13-byte ASCII line
//                "H=hhh T=ttt\r\n" and feeds it byte by byte to a UART
//                transmitter using its busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module dht11_uart_reporter #(
    parameter logic [7:0] TAG_H   = 8'h48,
    parameter logic [7:0] TAG_T   = 8'h54,
    parameter logic [7:0] ERR_CHR = 8'h2D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_humidity,
    input  logic [7:0] i_temperature,
    input  logic       i_chk_ok,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       o_busy,
    output logic       o_drop
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_IDX = 4'd12;
    localparam logic [2:0] c_LAST_DD  = 3'd7;

    state_t      r_state;
    // Each value is held as {hundreds, tens, units, binary} and shifted as one word.
    logic [19:0] r_hum_sr;
    logic [19:0] r_tmp_sr;
    logic        r_chk;
    logic [2:0]  r_cnt;
    logic [3:0]  r_idx;
    logic [7:0]  w_line_byte;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    // The top bit of an 8-bit conversion is always zero, so rotating it into
    // the LSB is the same as a zero fill.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] adj;
        adj = sr;
        if (sr[19:16] >= 4'd5) adj[19:16] = sr[19:16] + 4'd3;
        if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
        if (sr[11:8]  >= 4'd5) adj[11:8]  = sr[11:8]  + 4'd3;
        return {adj[18:0], adj[19]};
    endfunction

    // ASCII digit, or the error character when the checksum failed.
    function automatic logic [7:0] digit(input logic ok, input logic [3:0] nib);
        return ok ? {4'h3, nib} : ERR_CHR;
    endfunction

    // Select the line byte addressed by the current index.
    always_comb begin
        w_line_byte = 8'h00;
        case (r_idx)
            4'd0:    w_line_byte = TAG_H;
            4'd1:    w_line_byte = 8'h3D;
            4'd2:    w_line_byte = digit(r_chk, r_hum_sr[19:16]);
            4'd3:    w_line_byte = digit(r_chk, r_hum_sr[15:12]);
            4'd4:    w_line_byte = digit(r_chk, r_hum_sr[11:8]);
            4'd5:    w_line_byte = 8'h20;
            4'd6:    w_line_byte = TAG_T;
            4'd7:    w_line_byte = 8'h3D;
            4'd8:    w_line_byte = digit(r_chk, r_tmp_sr[19:16]);
            4'd9:    w_line_byte = digit(r_chk, r_tmp_sr[15:12]);
            4'd10:   w_line_byte = digit(r_chk, r_tmp_sr[11:8]);
            4'd11:   w_line_byte = 8'h0D;
            4'd12:   w_line_byte = 8'h0A;
            default: w_line_byte = 8'h00;
        endcase
    end

    // Capture, convert, then send the line one byte per tx handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_hum_sr <= 20'd0;
            r_tmp_sr <= 20'd0;
            r_chk    <= 1'b0;
            r_cnt    <= 3'd0;
            r_idx    <= 4'd0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            o_busy   <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            // Any reading arriving outside IDLE, including the cycle WAIT
            // returns to IDLE, is discarded.
            o_drop   <= i_valid && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_hum_sr <= {12'd0, i_humidity};
                        r_tmp_sr <= {12'd0, i_temperature};
                        r_chk    <= i_chk_ok;
                        r_cnt    <= 3'd0;
                        o_busy   <= 1'b1;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_hum_sr <= dd_step(r_hum_sr);
                    r_tmp_sr <= dd_step(r_tmp_sr);
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == c_LAST_DD) begin
                        r_idx   <= 4'd0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= w_line_byte;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (r_idx == c_LAST_IDX) begin
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_SEND;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht11_uart_reporter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dht11_uart_reporter
//  Description : Self-checking bench for dht11_uart_reporter with a UART
//                responder and a string-based reference of the output line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dht11_uart_reporter;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_valid;
    logic [7:0] i_humidity;
    logic [7:0] i_temperature;
    logic       i_chk_ok;
    logic       u_busy;
    logic       ext_busy;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       o_busy;
    logic       o_drop;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cnt = 0;
    int done_delay = 20;
    int done_count = 0;
    int v_cyc = 0;
    logic [7:0]   held;
    byte unsigned captured[$];
    int           start_cyc[$];

    assign tx_busy = u_busy | ext_busy;

    dht11_uart_reporter dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .i_humidity    (i_humidity),
        .i_temperature (i_temperature),
        .i_chk_ok      (i_chk_ok),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .o_busy        (o_busy),
        .o_drop        (o_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the line is just the decimal text of the reading.
    function automatic string mk_line(input int h, input int t, input bit ok);
        string hs, ts;
        hs = ok ? $sformatf("%03d", h) : "---";
        ts = ok ? $sformatf("%03d", t) : "---";
        return {"H=", hs, " T=", ts, "\r\n"};
    endfunction

    // UART responder: accepts a start, stays busy for done_delay cycles, pulses done.
    initial begin
        u_busy  = 1'b0;
        tx_done = 1'b0;
        held    = 8'h00;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (cnt > 0) begin
                chk("start_while_busy", 32'(tx_start), 32'd0);
                chk("data_hold", 32'(tx_data), 32'(held));
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    u_busy  = 1'b0;
                    done_count++;
                end
            end else if (tx_start === 1'b1) begin
                captured.push_back(tx_data);
                start_cyc.push_back(cyc);
                held   = tx_data;
                u_busy = 1'b1;
                cnt    = done_delay;
            end
        end
    end

    task automatic send(input int h, input int t, input bit ok);
        @(negedge clk);
        i_humidity    = 8'(h);
        i_temperature = 8'(t);
        i_chk_ok      = ok;
        i_valid       = 1'b1;
        v_cyc         = cyc;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic clear_capture();
        captured.delete();
        start_cyc.delete();
    endtask

    task automatic wait_line();
        int n;
        n = 0;
        while (!(captured.size() >= 13 && o_busy === 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_line(input string tag, input string exp);
        chk({tag, "_len"}, 32'(captured.size()), 32'd13);
        for (int i = 0; i < 13; i++) begin
            if (i < captured.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(captured[i]), 32'(exp[i]));
        end
        chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    endtask

    task automatic run_line(input string tag, input int h, input int t, input bit ok);
        clear_capture();
        send(h, t, ok);
        wait_line();
        check_line(tag, mk_line(h, t, ok));
    endtask

    initial begin
        int base;
        int n;
        int h, t;
        bit ok;
        reset = 1'b1; i_valid = 1'b0; i_humidity = 8'd0; i_temperature = 8'd0;
        i_chk_ok = 1'b0; ext_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_drop", 32'(o_drop), 32'd0);
        reset = 1'b0;

        // Basic line
        done_delay = 20;
        run_line("t1", 45, 23, 1'b1);

        // Extremes and first-start latency
        done_delay = 3;
        run_line("t2", 255, 0, 1'b1);
        if (start_cyc.size() > 0)
            chk("t2_latency", 32'(start_cyc[0] - v_cyc), 32'd10);

        // Checksum failure
        run_line("t3", 99, 99, 1'b0);

        // Second reading during byte 5 is dropped
        clear_capture();
        done_delay = 6;
        send(12, 34, 1'b1);
        n = 0;
        while (captured.size() < 5 && n < 2000) begin @(posedge clk); n++; end
        send(200, 100, 1'b1);
        chk("t4_drop_pulse", 32'(o_drop), 32'd1);
        @(negedge clk);
        chk("t4_drop_end", 32'(o_drop), 32'd0);
        wait_line();
        check_line("t4", mk_line(12, 34, 1'b1));
        repeat (30) @(negedge clk);
        chk("t4_no_second_line", 32'(captured.size()), 32'd13);

        // Held tx_busy on entering SEND
        clear_capture();
        ext_busy = 1'b1;
        send(7, 250, 1'b1);
        repeat (60) @(negedge clk);
        chk("t5_no_start", 32'(captured.size()), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd1);
        ext_busy = 1'b0;
        wait_line();
        check_line("t5", mk_line(7, 250, 1'b1));

        // Reset after the fifth tx_done
        clear_capture();
        done_delay = 8;
        base = done_count;
        send(77, 88, 1'b1);
        n = 0;
        while (done_count < base + 5 && n < 2000) begin @(posedge clk); n++; end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_tx_start", 32'(tx_start), 32'd0);
        chk("t6_tx_data", 32'(tx_data), 32'h00);
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_drop", 32'(o_drop), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_no_more_start", 32'(captured.size()), 32'd5);
        run_line("t6_after", 200, 9, 1'b1);

        // Randomised readings
        for (int k = 0; k < 8; k++) begin
            h  = int'($urandom_range(0, 255));
            t  = int'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            done_delay = int'($urandom_range(1, 25));
            run_line($sformatf("rnd%0d", k), h, t, ok);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
